kernel_sdram_local_bridge: RTL and testbench
============================================

Name: kernel_sdram_local_bridge

Overview:
- Avalon-MM burst slave, facing the Nios system interconnect, that drives the SDRAM controller PHY's native local_* request port.
- Sits directly upstream of the controller/PHY wrapper.
- Converts Avalon read/write bursts into local_* commands with correct burst-begin framing, local_ready back-pressure and init gating.
- Tracks outstanding read beats and passes read data back to Avalon.

Parameters:
- ADDR_W, 26: word address width, equal to local_address width.
- DATA_W, 32: data width; BE_W = DATA_W/8.
- BURST_W, 3: burstcount width, equal to local_size width.
- MAX_PEND_BEATS, 16: maximum outstanding read beats, range 8..63.
- AUTOPCH, 0: constant value driven on local_autopch_req.

Ports:
- clk  in  1  controller clock (phy_clk domain).
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  ADDR_W  Avalon word address.
- avs_read  in  1  read request.
- avs_write  in  1  write beat request.
- avs_writedata  in  DATA_W  write data.
- avs_byteenable  in  BE_W  byte enables.
- avs_burstcount  in  BURST_W  burst length, 1..4 beats.
- avs_waitrequest  out  1  stall.
- avs_readdata  out  DATA_W  read data.
- avs_readdatavalid  out  1  read data strobe.
- local_address  out  ADDR_W  command address.
- local_read_req  out  1  read command.
- local_write_req  out  1  write beat.
- local_burstbegin  out  1  first cycle of a new command.
- local_size  out  BURST_W  burst length.
- local_be  out  BE_W  byte enables.
- local_wdata  out  DATA_W  write data.
- local_autopch_req  out  1  auto-precharge, = AUTOPCH.
- local_ready  in  1  controller accepts the current cycle.
- local_init_done  in  1  calibration complete.
- local_rdata  in  DATA_W  read data.
- local_rdata_valid  in  1  read data strobe.
- err_unexpected_rdata  out  1  sticky protocol error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- On reset: FSM=IDLE; pend_cnt=0; beats_left=0; begin_sent=0; err flag=0; all req/valid outputs=0; address/size/be/wdata=0.
- Init gating: while local_init_done=0, avs_waitrequest=1 and no local request is issued.
- Burstcount normalisation: avs_burstcount=0, or any value >4, is treated as 1.
- FSM IDLE:
  - avs_write: drive local_write_req=1, local_burstbegin=!begin_sent, local_address/local_size from Avalon.
  - Beat accepted when local_ready=1. Then avs_waitrequest=0 that cycle.
  - If size>1: latch address and size, beats_left=size-1, go to WR_BURST. Otherwise stay in IDLE.
  - Write has priority over read if both are asserted (illegal for Avalon; defined anyway).
- Read issue in IDLE:
  - avs_read with pend_cnt+size <= MAX_PEND_BEATS: drive local_read_req=1, local_burstbegin=!begin_sent.
  - Accepted when local_ready=1; then pend_cnt += size.
  - If the credit check fails: avs_waitrequest=1 and local_read_req=0.
- FSM WR_BURST:
  - local_write_req follows avs_write; local_burstbegin=0; latched address/size held.
  - avs_waitrequest = !local_ready.
  - Each accepted beat decrements beats_left. On acceptance with beats_left=1, return to IDLE.
  - Reads stall in WR_BURST.
- begin_sent:
  - Set when local_burstbegin=1 and local_ready=0, so local_burstbegin is a single pulse per command even under stall.
  - Cleared on command acceptance.
- avs_waitrequest = !(local_ready & accepted-path-active); it is 1 in any cycle the current request is not accepted.
- pend_cnt:
  - Decrements by 1 on each local_rdata_valid.
  - Same-cycle accept and rdata_valid: pend_cnt += size-1.
  - Width is ceil(log2(MAX_PEND_BEATS+1)); never wraps.
- err_unexpected_rdata: set sticky on local_rdata_valid with pend_cnt=0; the counter is not decremented in that case.
- Read data path: avs_readdata=local_rdata and avs_readdatavalid=local_rdata_valid, combinational, zero latency.
- Reset mid-burst: FSM returns to IDLE immediately; partially issued bursts are abandoned; the controller is reset alongside.

Optional Feature:
- Macro: KERNEL_SDRAM_LOCAL_BRIDGE_RDATA_REG_EN.
- Defined: avs_readdata and avs_readdatavalid are registered, giving 1 cycle extra latency; valid resets to 0 and data to 0.
- Undefined: combinational pass-through as described above.

Decomposition:
- Package kernel_sdram_local_pkg holds:
  - FSM state typedef (IDLE, WR_BURST).
  - MAX_BURST=4 constant.
  - Burstcount-normalise function.
- One sub-module, kernel_sdram_rd_credit: holds pend_cnt, credit check and the error flag.

Test Plan:
- Hold local_init_done=0 for 50 cycles with avs_read=1 -> avs_waitrequest=1 throughout and no local_read_req; raise init_done -> read is issued on the next cycle.
- Write burst of 4 to 0x0000100 with local_ready low on beat 1 for 3 cycles:
  - local_burstbegin is high only in the first cycle.
  - local_size=4 and address 0x0000100 are held across all beats.
  - Exactly 4 accepted beats, then FSM returns to IDLE.
- MAX_PEND_BEATS=16 with four burst-4 reads and no rdata:
  - The 5th read stalls with waitrequest=1.
  - One local_rdata_valid still leaves pend 15+4>16, so the stall continues.
  - After 4 rdata_valid beats, the 5th read issues.
- Same-cycle read accept (size 2) and local_rdata_valid with pend_cnt=5 -> pend_cnt=6.
- local_rdata_valid with pend_cnt=0 -> err_unexpected_rdata=1 and stays 1 until reset; pend_cnt stays 0.
- Assert reset during beat 2 of a 4-beat write -> all outputs 0 asynchronously; after release, a single-beat write issues with burstbegin=1 and local_size=1.

Source files
------------

// File: rtl/kernel_sdram_local_pkg.sv
// Shared types and helpers for the Avalon-MM to SDRAM local_* bridge.
package kernel_sdram_local_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WR_BURST = 1'b1
  } state_t;

  localparam int MAX_BURST = 4;

  // Zero or over-long burstcounts collapse to a single beat.
  function automatic logic [2:0] norm_burst(input logic [15:0] bc);
    if (bc == 16'd0 || bc > 16'(MAX_BURST)) return 3'd1;
    return bc[2:0];
  endfunction

endpackage

// File: rtl/kernel_sdram_rd_credit.sv
// Outstanding read-beat credit counter with sticky unexpected-rdata error flag.
module kernel_sdram_rd_credit #(
  parameter int BURST_W        = 3,
  parameter int MAX_PEND_BEATS = 16,
  localparam int PEND_W        = $clog2(MAX_PEND_BEATS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BURST_W-1:0] req_size,
  input  logic               rd_accept,
  input  logic               rdata_valid,
  output logic               credit_ok,
  output logic               err_unexpected_rdata
);

  logic [PEND_W-1:0] pend_cnt;
  logic [PEND_W:0]   size_ext;
  logic              dec;

  assign size_ext  = (PEND_W+1)'(req_size);
  assign credit_ok = ({1'b0, pend_cnt} + size_ext) <= (PEND_W+1)'(MAX_PEND_BEATS);
  // Data with nothing outstanding is flagged rather than allowed to underflow.
  assign dec       = rdata_valid && (pend_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_cnt             <= '0;
      err_unexpected_rdata <= 1'b0;
    end else begin
      pend_cnt <= pend_cnt + (rd_accept ? PEND_W'(req_size) : '0) - PEND_W'(dec);
      if (rdata_valid && (pend_cnt == '0)) err_unexpected_rdata <= 1'b1;
    end
  end

endmodule

// File: rtl/kernel_sdram_local_bridge.sv
// Avalon-MM burst slave driving the SDRAM controller local_* port.
// Define KERNEL_SDRAM_LOCAL_BRIDGE_RDATA_REG_EN to register the read data return path.
module kernel_sdram_local_bridge
  import kernel_sdram_local_pkg::*;
#(
  parameter int ADDR_W         = 26,
  parameter int DATA_W         = 32,
  parameter int BURST_W        = 3,
  parameter int MAX_PEND_BEATS = 16,
  parameter bit AUTOPCH        = 1'b0,
  localparam int BE_W          = DATA_W / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [DATA_W-1:0]  avs_writedata,
  input  logic [BE_W-1:0]    avs_byteenable,
  input  logic [BURST_W-1:0] avs_burstcount,
  output logic               avs_waitrequest,
  output logic [DATA_W-1:0]  avs_readdata,
  output logic               avs_readdatavalid,
  output logic [ADDR_W-1:0]  local_address,
  output logic               local_read_req,
  output logic               local_write_req,
  output logic               local_burstbegin,
  output logic [BURST_W-1:0] local_size,
  output logic [BE_W-1:0]    local_be,
  output logic [DATA_W-1:0]  local_wdata,
  output logic               local_autopch_req,
  input  logic               local_ready,
  input  logic               local_init_done,
  input  logic [DATA_W-1:0]  local_rdata,
  input  logic               local_rdata_valid,
  output logic               err_unexpected_rdata
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [BURST_W-1:0] size_q, beats_left_q, norm_size;
  logic               begin_sent_q, wr_accept, rd_accept, credit_ok;

  assign norm_size         = BURST_W'(norm_burst(16'(avs_burstcount)));
  assign local_autopch_req = AUTOPCH;

  kernel_sdram_rd_credit #(
    .BURST_W        (BURST_W),
    .MAX_PEND_BEATS (MAX_PEND_BEATS)
  ) u_rd_credit (
    .clk                  (clk),
    .reset                (reset),
    .req_size             (norm_size),
    .rd_accept            (rd_accept),
    .rdata_valid          (local_rdata_valid),
    .credit_ok            (credit_ok),
    .err_unexpected_rdata (err_unexpected_rdata)
  );

  // Outputs are forced quiet during reset so nothing leaks to the controller asynchronously.
  always_comb begin
    state_d          = state_q;
    local_read_req   = 1'b0;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    local_address    = '0;
    local_size       = '0;
    local_be         = '0;
    local_wdata      = '0;
    avs_waitrequest  = 1'b1;
    wr_accept        = 1'b0;
    rd_accept        = 1'b0;
    if (!reset && local_init_done) begin
      case (state_q)
        IDLE: begin
          if (avs_write) begin
            local_write_req  = 1'b1;
            local_burstbegin = !begin_sent_q;
            local_address    = avs_address;
            local_size       = norm_size;
            local_be         = avs_byteenable;
            local_wdata      = avs_writedata;
            wr_accept        = local_ready;
            avs_waitrequest  = !local_ready;
            if (local_ready && norm_size > BURST_W'(1)) state_d = WR_BURST;
          end else if (avs_read && credit_ok) begin
            local_read_req   = 1'b1;
            local_burstbegin = !begin_sent_q;
            local_address    = avs_address;
            local_size       = norm_size;
            local_be         = avs_byteenable;
            rd_accept        = local_ready;
            avs_waitrequest  = !local_ready;
          end
        end
        WR_BURST: begin
          local_write_req = avs_write;
          local_address   = addr_q;
          local_size      = size_q;
          local_be        = avs_byteenable;
          local_wdata     = avs_writedata;
          avs_waitrequest = !local_ready;
          wr_accept       = avs_write && local_ready;
          if (wr_accept && beats_left_q == BURST_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      beats_left_q <= '0;
      begin_sent_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && wr_accept) begin
        addr_q       <= avs_address;
        size_q       <= norm_size;
        beats_left_q <= norm_size - 1'b1;
      end else if (state_q == WR_BURST && wr_accept) begin
        beats_left_q <= beats_left_q - 1'b1;
      end
      // Remember a stalled burstbegin so it pulses only once per command.
      if (wr_accept || rd_accept) begin_sent_q <= 1'b0;
      else if (local_burstbegin && !local_ready) begin_sent_q <= 1'b1;
    end
  end

`ifdef KERNEL_SDRAM_LOCAL_BRIDGE_RDATA_REG_EN
  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;

  // Stage p1: registered read return
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      rdata_p1 <= local_rdata;
      vld_p1   <= local_rdata_valid;
    end
  end

  assign avs_readdata      = rdata_p1;
  assign avs_readdatavalid = vld_p1;
`else
  assign avs_readdata      = local_rdata;
  assign avs_readdatavalid = local_rdata_valid;
`endif

endmodule

// File: tb/tb_kernel_sdram_local_bridge.sv
// Directed bench for kernel_sdram_local_bridge: gating, write bursts, read credit, error flag, reset.
module tb_kernel_sdram_local_bridge;
  import kernel_sdram_local_pkg::*;

  localparam int ADDR_W = 26, DATA_W = 32, BE_W = 4, BURST_W = 3, MAX_PEND_BEATS = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  avs_address;
  logic               avs_read, avs_write;
  logic [DATA_W-1:0]  avs_writedata;
  logic [BE_W-1:0]    avs_byteenable;
  logic [BURST_W-1:0] avs_burstcount;
  logic               avs_waitrequest;
  logic [DATA_W-1:0]  avs_readdata;
  logic               avs_readdatavalid;
  logic [ADDR_W-1:0]  local_address;
  logic               local_read_req, local_write_req, local_burstbegin;
  logic [BURST_W-1:0] local_size;
  logic [BE_W-1:0]    local_be;
  logic [DATA_W-1:0]  local_wdata;
  logic               local_autopch_req;
  logic               local_ready, local_init_done;
  logic [DATA_W-1:0]  local_rdata;
  logic               local_rdata_valid;
  logic               err_unexpected_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kernel_sdram_local_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
    .MAX_PEND_BEATS(MAX_PEND_BEATS), .AUTOPCH(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .local_address(local_address), .local_read_req(local_read_req),
    .local_write_req(local_write_req), .local_burstbegin(local_burstbegin),
    .local_size(local_size), .local_be(local_be), .local_wdata(local_wdata),
    .local_autopch_req(local_autopch_req), .local_ready(local_ready),
    .local_init_done(local_init_done), .local_rdata(local_rdata),
    .local_rdata_valid(local_rdata_valid), .err_unexpected_rdata(err_unexpected_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    avs_byteenable = '0; avs_burstcount = '0;
    local_ready = 1'b0; local_init_done = 1'b0; local_rdata = '0; local_rdata_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({local_read_req, local_write_req, local_burstbegin} !== 3'b000) begin
      errors++; $display("FAIL reset_reqs got %b want 000", {local_read_req, local_write_req, local_burstbegin});
    end
    checks++;
    if (local_address !== '0 || local_size !== '0 || local_be !== '0 || local_wdata !== '0) begin
      errors++; $display("FAIL reset_cmd got addr=%h size=%0d be=%h wdata=%h want 0", local_address, local_size, local_be, local_wdata);
    end
    checks++;
    if (err_unexpected_rdata !== 1'b0 || avs_readdatavalid !== 1'b0 || local_autopch_req !== 1'b0) begin
      errors++; $display("FAIL reset_flags got err=%b rdv=%b apch=%b want 0", err_unexpected_rdata, avs_readdatavalid, local_autopch_req);
    end
    checks++;
    if (dut.u_rd_credit.pend_cnt !== '0 || dut.state_q !== IDLE) begin
      errors++; $display("FAIL reset_state got pend=%0d state=%0d want 0/IDLE", dut.u_rd_credit.pend_cnt, dut.state_q);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_init_gating();
    int bad;
    bad = 0;
    local_ready = 1'b1; avs_address = 26'h40; avs_burstcount = 3'd1; avs_byteenable = 4'hF; avs_read = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (avs_waitrequest !== 1'b1 || local_read_req !== 1'b0) bad++;
      next_cycle();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL init_gate bad_cycles got %0d want 0", bad);
    end
    local_init_done = 1'b1;
    @(negedge clk);
    checks++;
    if (local_read_req !== 1'b1 || local_burstbegin !== 1'b1 || avs_waitrequest !== 1'b0) begin
      errors++; $display("FAIL init_release got rreq=%b bb=%b wr=%b want 1 1 0", local_read_req, local_burstbegin, avs_waitrequest);
    end
    checks++;
    if (local_address !== 26'h40 || local_size !== 3'd1) begin
      errors++; $display("FAIL init_cmd got addr=%h size=%0d want 40 1", local_address, local_size);
    end
    next_cycle();
    avs_read = 1'b0;
    checks++;
    if (dut.u_rd_credit.pend_cnt !== 5'd1) begin
      errors++; $display("FAIL init_pend got %0d want 1", dut.u_rd_credit.pend_cnt);
    end
    local_rdata = 32'hDEADBEEF; local_rdata_valid = 1'b1;
    @(negedge clk);
`ifndef KERNEL_SDRAM_LOCAL_BRIDGE_RDATA_REG_EN
    checks++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rdata_pass got v=%b d=%h want 1 deadbeef", avs_readdatavalid, avs_readdata);
    end
`endif
    next_cycle();
    local_rdata_valid = 1'b0; local_rdata = '0;
`ifdef KERNEL_SDRAM_LOCAL_BRIDGE_RDATA_REG_EN
    @(negedge clk);
    checks++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rdata_reg got v=%b d=%h want 1 deadbeef", avs_readdatavalid, avs_readdata);
    end
    next_cycle();
`endif
    checks++;
    if (dut.u_rd_credit.pend_cnt !== 5'd0) begin
      errors++; $display("FAIL init_drain got %0d want 0", dut.u_rd_credit.pend_cnt);
    end
  endtask

  task automatic test_write_burst();
    int bb_cnt, accepted, hold_bad;
    logic first_bb;
    bb_cnt = 0; accepted = 0; hold_bad = 0; first_bb = 1'b0;
    avs_address = 26'h100; avs_burstcount = 3'd4; avs_writedata = 32'hA000_0000;
    avs_byteenable = 4'hF; avs_write = 1'b1; local_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) first_bb = local_burstbegin;
      if (local_burstbegin === 1'b1) bb_cnt++;
      if (avs_waitrequest !== 1'b1 || local_write_req !== 1'b1 ||
          local_address !== 26'h100 || local_size !== 3'd4) hold_bad++;
      next_cycle();
    end
    local_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (local_burstbegin === 1'b1) bb_cnt++;
      if (local_write_req === 1'b1 && avs_waitrequest === 1'b0) accepted++;
      if (local_address !== 26'h100 || local_size !== 3'd4 ||
          local_wdata !== 32'hA000_0000 + 32'(b)) hold_bad++;
      next_cycle();
      avs_writedata = 32'hA000_0001 + 32'(b); avs_address = 26'h3FF; avs_burstcount = 3'd1;
    end
    avs_write = 1'b0;
    checks++;
    if (first_bb !== 1'b1 || bb_cnt != 1) begin
      errors++; $display("FAIL wr_burstbegin got first=%b count=%0d want 1 1", first_bb, bb_cnt);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++; $display("FAIL wr_hold bad_cycles got %0d want 0", hold_bad);
    end
    checks++;
    if (accepted != 4) begin
      errors++; $display("FAIL wr_beats got %0d want 4", accepted);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL wr_return got state=%0d want IDLE", dut.state_q);
    end
  endtask

  task automatic test_burst_norm();
    logic [2:0] bcs [3];
    bcs = '{3'd0, 3'd5, 3'd7};
    local_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      avs_write = 1'b1; avs_burstcount = bcs[i]; avs_address = 26'h20 + 26'(i);
      @(negedge clk);
      checks++;
      if (local_size !== 3'd1 || local_burstbegin !== 1'b1 || local_write_req !== 1'b1) begin
        errors++; $display("FAIL norm_bc%0d got size=%0d bb=%b wreq=%b want 1 1 1", bcs[i], local_size, local_burstbegin, local_write_req);
      end
      next_cycle();
      avs_write = 1'b0;
      checks++;
      if (dut.state_q !== IDLE) begin
        errors++; $display("FAIL norm_idle_bc%0d got state=%0d want IDLE", bcs[i], dut.state_q);
      end
    end
  endtask

  task automatic test_credit();
    int bad, bad2;
    bad = 0; bad2 = 0;
    local_ready = 1'b1; avs_read = 1'b1; avs_burstcount = 3'd4;
    for (int i = 0; i < 4; i++) begin
      avs_address = 26'h200 + 26'(i * 4);
      @(negedge clk);
      if (local_read_req !== 1'b1 || avs_waitrequest !== 1'b0) bad++;
      next_cycle();
    end
    checks++;
    if (bad != 0 || dut.u_rd_credit.pend_cnt !== 5'd16) begin
      errors++; $display("FAIL credit_fill got bad=%0d pend=%0d want 0 16", bad, dut.u_rd_credit.pend_cnt);
    end
    avs_address = 26'h210;
    @(negedge clk);
    checks++;
    if (local_read_req !== 1'b0 || avs_waitrequest !== 1'b1) begin
      errors++; $display("FAIL credit_stall got rreq=%b wr=%b want 0 1", local_read_req, avs_waitrequest);
    end
    next_cycle();
    local_rdata_valid = 1'b1;
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      if (local_read_req !== 1'b0 || avs_waitrequest !== 1'b1) bad2++;
      next_cycle();
    end
    local_rdata_valid = 1'b0;
    checks++;
    if (bad2 != 0 || dut.u_rd_credit.pend_cnt !== 5'd12) begin
      errors++; $display("FAIL credit_hold got bad=%0d pend=%0d want 0 12", bad2, dut.u_rd_credit.pend_cnt);
    end
    @(negedge clk);
    checks++;
    if (local_read_req !== 1'b1 || avs_waitrequest !== 1'b0 || local_address !== 26'h210) begin
      errors++; $display("FAIL credit_release got rreq=%b wr=%b addr=%h want 1 0 210", local_read_req, avs_waitrequest, local_address);
    end
    next_cycle();
    avs_read = 1'b0;
    local_rdata_valid = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    local_rdata_valid = 1'b0;
    checks++;
    if (dut.u_rd_credit.pend_cnt !== 5'd5) begin
      errors++; $display("FAIL credit_drain got %0d want 5", dut.u_rd_credit.pend_cnt);
    end
  endtask

  task automatic test_same_cycle();
    avs_read = 1'b1; avs_burstcount = 3'd2; avs_address = 26'h300; local_rdata_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (local_read_req !== 1'b1 || local_size !== 3'd2) begin
      errors++; $display("FAIL same_issue got rreq=%b size=%0d want 1 2", local_read_req, local_size);
    end
    next_cycle();
    avs_read = 1'b0; local_rdata_valid = 1'b0;
    checks++;
    if (dut.u_rd_credit.pend_cnt !== 5'd6) begin
      errors++; $display("FAIL same_pend got %0d want 6", dut.u_rd_credit.pend_cnt);
    end
    local_rdata_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    local_rdata_valid = 1'b0;
    checks++;
    if (dut.u_rd_credit.pend_cnt !== 5'd0 || err_unexpected_rdata !== 1'b0) begin
      errors++; $display("FAIL same_drain got pend=%0d err=%b want 0 0", dut.u_rd_credit.pend_cnt, err_unexpected_rdata);
    end
  endtask

  task automatic test_err();
    local_rdata_valid = 1'b1;
    next_cycle();
    local_rdata_valid = 1'b0;
    checks++;
    if (err_unexpected_rdata !== 1'b1 || dut.u_rd_credit.pend_cnt !== 5'd0) begin
      errors++; $display("FAIL err_set got err=%b pend=%0d want 1 0", err_unexpected_rdata, dut.u_rd_credit.pend_cnt);
    end
    repeat (5) next_cycle();
    checks++;
    if (err_unexpected_rdata !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b want 1", err_unexpected_rdata);
    end
  endtask

  task automatic test_reset_mid_burst();
    local_ready = 1'b1; avs_write = 1'b1; avs_address = 26'h180; avs_burstcount = 3'd4;
    avs_writedata = 32'h1234_5678; avs_byteenable = 4'hF;
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if ({local_read_req, local_write_req, local_burstbegin} !== 3'b000 ||
        local_address !== '0 || local_size !== '0 || local_be !== '0 || local_wdata !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got req=%b addr=%h size=%0d be=%h wdata=%h want 0",
                         {local_read_req, local_write_req, local_burstbegin}, local_address, local_size, local_be, local_wdata);
    end
    checks++;
    if (dut.state_q !== IDLE || err_unexpected_rdata !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state got state=%0d err=%b want IDLE 0", dut.state_q, err_unexpected_rdata);
    end
    next_cycle();
    reset = 1'b0; avs_address = 26'h55; avs_burstcount = 3'd1;
    @(negedge clk);
    checks++;
    if (local_write_req !== 1'b1 || local_burstbegin !== 1'b1 || local_size !== 3'd1 || local_address !== 26'h55) begin
      errors++; $display("FAIL rst_mid_single got wreq=%b bb=%b size=%0d addr=%h want 1 1 1 55",
                         local_write_req, local_burstbegin, local_size, local_address);
    end
    next_cycle();
    avs_write = 1'b0;
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL rst_mid_idle got state=%0d want IDLE", dut.state_q);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init_gating();
    test_write_burst();
    test_burst_norm();
    test_credit();
    test_same_cycle();
    test_err();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
